// File: rtl/exp_golomb_pipe_decoder.sv
// Two-stage pipelined Exp-Golomb decoder: S1 registers the window and the
// leading-one position, S2 produces ue/se/te results with valid/ready handshake.
module exp_golomb_pipe_decoder #(
    parameter int WIN_W = 32,
    parameter int VAL_W = WIN_W / 2,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIN_W-1:0] BitStream_buffer_output,
    input  logic [1:0]       mode,
    input  logic             te_max1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] code_num,
    output logic [VAL_W-1:0] se_value,
    output logic [LEN_W-1:0] code_len,
    output logic             err,
    output logic             err_sticky,
    output logic [15:0]      sym_count
);

    localparam int MAX_LZ = WIN_W / 2 - 1;

    typedef enum logic [1:0] {
        MODE_UE  = 2'b00,
        MODE_SE  = 2'b01,
        MODE_TE  = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    logic             s1_valid;
    logic [WIN_W-1:0] s1_win;
    mode_t            s1_mode;
    logic             s1_te1;
    logic [LEN_W-1:0] s1_lz;
    logic             s1_none;

    logic [LEN_W-1:0] lz_found;
    logic             none_found;

    logic             s2_accept;
    logic             accept_in;
    logic             delivered;

    logic [LEN_W-1:0] lz2;
    logic [LEN_W-1:0] shamt;
    logic [VAL_W-1:0] ue_num;
    logic [VAL_W-1:0] half;
    logic [VAL_W-1:0] nxt_num;
    logic [VAL_W-1:0] nxt_se;
    logic [LEN_W-1:0] nxt_len;
    logic             nxt_err;

    // S2 can take a new symbol when empty or when its current one is leaving;
    // S1 can take one when empty or when it is moving into S2.
    assign s2_accept = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_accept;
    assign accept_in = in_valid && in_ready && !flush;
    assign delivered = out_valid && out_ready;

    // Priority search for the first 1 from the MSB; the lowest index wins because it is assigned last.
    always_comb begin
        lz_found   = '0;
        none_found = 1'b1;
        for (int i = MAX_LZ; i >= 0; i--) begin
            if (BitStream_buffer_output[WIN_W-1-i]) begin
                lz_found   = LEN_W'(i);
                none_found = 1'b0;
            end
        end
    end

    // Stage 1 register: window, mode and leading-zero count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_win   <= '0;
            s1_mode  <= MODE_UE;
            s1_te1   <= 1'b0;
            s1_lz    <= '0;
            s1_none  <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept_in) begin
                s1_win  <= BitStream_buffer_output;
                s1_mode <= mode_t'(mode);
                s1_te1  <= te_max1;
                s1_lz   <= lz_found;
                s1_none <= none_found;
            end
        end
    end

    // Stage 2 decode: shifting the window right so the leading one lands at
    // bit LZ gives 2^LZ + INFO, which minus one is codeNum.
    always_comb begin
        lz2     = s1_lz << 1;
        shamt   = LEN_W'(WIN_W - 1) - lz2;
        ue_num  = VAL_W'(s1_win >> shamt) - VAL_W'(1);
        half    = ue_num >> 1;
        nxt_num = ue_num;
        nxt_se  = '0;
        nxt_len = lz2 + LEN_W'(1);
        nxt_err = 1'b0;
        if (s1_mode == MODE_TE && s1_te1) begin
            nxt_num = {{(VAL_W-1){1'b0}}, ~s1_win[WIN_W-1]};
            nxt_len = LEN_W'(1);
        end else if (s1_mode == MODE_RSV || s1_none) begin
            nxt_num = '0;
            nxt_len = '0;
            nxt_err = 1'b1;
        end else if (s1_mode == MODE_SE) begin
            nxt_se = ue_num[0] ? (half + VAL_W'(1)) : (-half);
        end
    end

    // Stage 2 output register; holds steady while the downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            code_num  <= '0;
            se_value  <= '0;
            code_len  <= '0;
            err       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                code_num <= nxt_num;
                se_value <= nxt_se;
                code_len <= nxt_len;
                err      <= nxt_err;
            end
        end
    end

    // Delivered-symbol counter and sticky error flag; untouched by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_count  <= '0;
            err_sticky <= 1'b0;
        end else if (delivered) begin
            sym_count <= sym_count + 16'd1;
            if (err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exp_golomb_pipe_decoder.sv
// Directed, scoreboard-based bench for exp_golomb_pipe_decoder.
module tb_exp_golomb_pipe_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] win;
    logic [1:0]  mode;
    logic        te_max1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] code_num;
    logic [15:0] se_value;
    logic [5:0]  code_len;
    logic        err;
    logic        err_sticky;
    logic [15:0] sym_count;

    typedef struct packed {
        logic [15:0] cn;
        logic [15:0] se;
        logic [5:0]  len;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_count  = '0;
    logic        exp_sticky = 1'b0;
    bit          acc;

    exp_golomb_pipe_decoder dut (
        .clk                     (clk),
        .reset                   (reset),
        .flush                   (flush),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .BitStream_buffer_output (win),
        .mode                    (mode),
        .te_max1                 (te_max1),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .code_num                (code_num),
        .se_value                (se_value),
        .code_len                (code_len),
        .err                     (err),
        .err_sticky              (err_sticky),
        .sym_count               (sym_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Reference decoder written from the bitstream definition.
    function automatic exp_t model(logic [31:0] w, logic [1:0] m, logic t1);
        exp_t r;
        int   lz;
        int   info;
        int   cn;
        r  = '0;
        lz = -1;
        for (int i = 0; i < 16; i++) begin
            if (lz < 0 && w[31-i]) lz = i;
        end
        if (m == 2'b10 && t1) begin
            r.cn  = {15'd0, ~w[31]};
            r.len = 6'd1;
        end else if (m == 2'b11 || lz < 0) begin
            r.err = 1'b1;
        end else begin
            info = 0;
            for (int j = 0; j < lz; j++) info = info * 2 + int'(w[30-lz-j]);
            cn    = (1 << lz) - 1 + info;
            r.cn  = 16'(cn);
            r.len = 6'(2 * lz + 1);
            if (m == 2'b01) r.se = (cn % 2 == 1) ? 16'((cn + 1) / 2) : 16'(-(cn / 2));
        end
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: compare any presented output against the scoreboard head,
    // then update the scoreboard for what the edge delivers/accepts/flushes.
    task automatic apply_stimulus(output bit accepted);
        bit   del;
        exp_t head;
        head = '0;
        @(negedge clk);
        accepted = in_valid && in_ready && !flush;
        del      = out_valid && out_ready;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                head = sb[0];
                check_output("code_num", 32'(code_num), 32'(head.cn));
                check_output("se_value", 32'(se_value), 32'(head.se));
                check_output("code_len", 32'(code_len), 32'(head.len));
                check_output("err",      32'(err),      32'(head.err));
            end
        end
        if (del) begin
            exp_count++;
            if (sb.size() > 0) begin
                void'(sb.pop_front());
                if (head.err) exp_sticky = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (flush) sb.delete();
        if (accepted) sb.push_back(model(win, mode, te_max1));
        check_output("sym_count",  32'(sym_count),  32'(exp_count));
        check_output("err_sticky", 32'(err_sticky), 32'(exp_sticky));
    endtask

    task automatic send_one(input logic [31:0] w, input logic [1:0] m, input logic t1);
        bit a;
        a        = 1'b0;
        win      = w;
        mode     = m;
        te_max1  = t1;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !a; i++) apply_stimulus(a);
        in_valid = 1'b0;
        check_output("accept_timeout", 32'(a), 32'd1);
    endtask

    task automatic drain();
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() > 0 || out_valid); i++) apply_stimulus(a);
        check_output("drain_empty", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        win       = '0;
        mode      = 2'b00;
        te_max1   = 1'b0;
        out_ready = 1'b1;
        #12;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_code_num",  32'(code_num),  32'd0);
        check_output("rst_code_len",  32'(code_len),  32'd0);
        check_output("rst_sym_count", 32'(sym_count), 32'd0);
        check_output("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency: output appears on the second edge after presentation.
        win = 32'h3800_0000; mode = 2'b00; te_max1 = 1'b0; in_valid = 1'b1;
        apply_stimulus(acc);
        check_output("first_accept", 32'(acc), 32'd1);
        check_output("latency_s1", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        apply_stimulus(acc);
        check_output("latency_s2", 32'(out_valid), 32'd1);
        drain();

        // Directed decode cases, back to back.
        send_one(32'h3800_0000, 2'b01, 1'b0);
        send_one(32'h3000_0000, 2'b01, 1'b0);
        send_one(32'h8000_0000, 2'b01, 1'b0);
        send_one(32'h7FFF_FFFF, 2'b10, 1'b1);
        send_one(32'h7FFF_FFFF, 2'b10, 1'b0);
        send_one(32'h0001_0000, 2'b00, 1'b0);
        send_one(32'h0001_FFFF, 2'b00, 1'b0);
        send_one(32'h1234_5678, 2'b00, 1'b0);
        send_one(32'h0000_0000, 2'b00, 1'b0);
        send_one(32'h5000_0000, 2'b00, 1'b0);
        send_one(32'h8000_0000, 2'b11, 1'b0);
        for (int k = 0; k < 6; k++) send_one($urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        drain();
        check_output("sticky_after_err", 32'(err_sticky), 32'd1);

        // Flush with two in flight, downstream stalled.
        out_ready = 1'b0;
        send_one(32'h2000_0000, 2'b00, 1'b0);
        send_one(32'h4000_0000, 2'b01, 1'b0);
        flush = 1'b1; in_valid = 1'b1; win = 32'h8000_0000;
        apply_stimulus(acc);
        flush = 1'b0; in_valid = 1'b0;
        apply_stimulus(acc);
        apply_stimulus(acc);
        check_output("flush_cleared", 32'(out_valid), 32'd0);

        // Flush while the output is being delivered: it still counts.
        send_one(32'h2000_0000, 2'b00, 1'b0);
        send_one(32'h4000_0000, 2'b01, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        apply_stimulus(acc);
        flush = 1'b0;
        drain();

        // Asynchronous reset in the middle of a stream.
        send_one(32'h1000_0000, 2'b00, 1'b0);
        send_one(32'h0800_0000, 2'b01, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("arst_out_valid",  32'(out_valid),  32'd0);
        check_output("arst_code_num",   32'(code_num),   32'd0);
        check_output("arst_se_value",   32'(se_value),   32'd0);
        check_output("arst_err",        32'(err),        32'd0);
        check_output("arst_err_sticky", 32'(err_sticky), 32'd0);
        check_output("arst_sym_count",  32'(sym_count),  32'd0);
        check_output("arst_in_ready",   32'(in_ready),   32'd1);
        sb.delete();
        exp_count  = '0;
        exp_sticky = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: out_ready low for three cycles while five symbols stream in.
        out_ready = 1'b0;
        send_one(32'h3800_0000, 2'b01, 1'b0);
        send_one(32'h3000_0000, 2'b01, 1'b0);
        check_output("in_ready_full", 32'(in_ready), 32'd0);
        win = 32'h0001_0000; mode = 2'b00; in_valid = 1'b1;
        apply_stimulus(acc);
        check_output("stall_no_accept", 32'(acc), 32'd0);
        out_ready = 1'b1;
        send_one(32'h0001_0000, 2'b00, 1'b0);
        send_one(32'h7FFF_FFFF, 2'b10, 1'b1);
        send_one(32'h4000_0000, 2'b01, 1'b0);
        drain();
        check_output("sym_count_final", 32'(sym_count), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
